// File: rtl/matrix_line_writer.sv
// Streams a captured LINES x LINE_W state snapshot to line memory, one line per
// accepted write, with ready/valid back-pressure and a one-cycle done pulse.
module matrix_line_writer #(
  parameter int LINES     = 64,
  parameter int LINE_W    = 25,
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LINES*LINE_W-1:0]  state_in,
  input  logic                     mem_ready,
  output logic                     mem_wr_en,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [LINE_W-1:0]        mem_line,
  output logic [ADDR_W:0]          line_cnt,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [LINE_W-1:0]   r_snap [LINES];
  logic [ADDR_W-1:0]   r_idx;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_line;
  logic [ADDR_W:0]     r_cnt;
  logic                r_busy;
  logic                r_done;

  logic [LINE_W-1:0]   w_lines [LINES];
  logic [ADDR_W-1:0]   w_next_idx;
  logic                w_last;

  for (genvar gi = 0; gi < LINES; gi++) begin : g_unpack
    assign w_lines[gi] = state_in[gi*LINE_W +: LINE_W];
  end

  assign w_next_idx = r_idx + ADDR_W'(1);
  assign w_last     = (r_idx == ADDR_W'(LINES - 1));

  // Address/data for the next line are preloaded on each accept so that the
  // outputs never depend combinationally on mem_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_line  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < LINES; i++) r_snap[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            for (int i = 0; i < LINES; i++) r_snap[i] <= w_lines[i];
            r_idx   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_wr_en <= 1'b1;
            r_addr  <= ADDR_W'(BASE_ADDR);
            r_line  <= w_lines[0];
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            r_cnt <= r_cnt + (ADDR_W+1)'(1);
            if (w_last) begin
              r_wr_en <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx  <= w_next_idx;
              r_addr <= ADDR_W'(BASE_ADDR) + w_next_idx;
              r_line <= r_snap[w_next_idx];
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_wr_en = r_wr_en;
  assign mem_addr  = r_addr;
  assign mem_line  = r_line;
  assign line_cnt  = r_cnt;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
